// File: rtl/hub75e_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : hub75e_frame_writer
// Purpose  : Write side of the HUB75E double-buffered frame memory. Packs the
//            D/C-qualified SPI byte stream into RGB888 pixels and writes them
//            in raster order into the back buffer. Once a full frame is in,
//            the buffers are swapped at the next scan-frame boundary.
// Ports    : clk_i, rst_n_i           - clock, async active-low reset
//            dc_i, spi_byte_vld_i,
//            spi_byte_data_i          - byte stream from spi_slave
//            rd_frame_end_i           - end-of-scan pulse from waveform_gen
//            ram_wr_en_o/sel_o/addr_o/
//            data_o/done_o            - back-buffer write port
//            frame_sel_o              - buffer currently displayed
//            ovf_o                    - sticky dropped-byte flag
// Revision : 1.0 - initial release
// ============================================================================
module hub75e_frame_writer #(
  parameter int         COL_BITS     = 6,
  parameter int         ROW_BITS     = 6,
  parameter logic [7:0] CMD_WR_START = 8'h2C
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         dc_i,
  input  logic                         spi_byte_vld_i,
  input  logic [7:0]                   spi_byte_data_i,
  input  logic                         rd_frame_end_i,
  output logic                         ram_wr_en_o,
  output logic                         ram_wr_sel_o,
  output logic [COL_BITS+ROW_BITS-1:0] ram_wr_addr_o,
  output logic [23:0]                  ram_wr_data_o,
  output logic                         ram_wr_done_o,
  output logic                         frame_sel_o,
  output logic                         ovf_o
);

  localparam int ADDR_W = COL_BITS + ROW_BITS;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_WAIT_SWAP = 2'd2
  } state_e;

  state_e              state_q,     state_d;
  logic [COL_BITS-1:0] col_q,       col_d;
  logic [ROW_BITS-1:0] row_q,       row_d;
  logic [1:0]          phase_q,     phase_d;
  logic [15:0]         pix_q,       pix_d;      // {R, G} gathered so far
  logic                wr_en_q,     wr_en_d;
  logic                wr_sel_q,    wr_sel_d;
  logic [ADDR_W-1:0]   wr_addr_q,   wr_addr_d;
  logic [23:0]         wr_data_q,   wr_data_d;
  logic                wr_done_q,   wr_done_d;
  logic                frame_sel_q, frame_sel_d;
  logic                ovf_q,       ovf_d;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    phase_d     = phase_q;
    pix_d       = pix_q;
    wr_en_d     = 1'b0;
    wr_sel_d    = wr_sel_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_done_d   = 1'b0;
    frame_sel_d = frame_sel_q;
    ovf_d       = ovf_q;

    if (spi_byte_vld_i) begin
      if (!dc_i) begin
        if (spi_byte_data_i == CMD_WR_START) begin
          if (state_q == ST_WAIT_SWAP) begin
            ovf_d = 1'b1;
          end else begin
            // (Re)open a frame; any partial pixel is discarded via phase reset.
            state_d = ST_WRITE;
            col_d   = '0;
            row_d   = '0;
            phase_d = 2'd0;
          end
        end
      end else begin
        case (state_q)
          ST_WRITE: begin
            case (phase_q)
              2'd0: begin
                pix_d[15:8] = spi_byte_data_i;
                phase_d     = 2'd1;
              end
              2'd1: begin
                pix_d[7:0] = spi_byte_data_i;
                phase_d    = 2'd2;
              end
              default: begin
                phase_d   = 2'd0;
                wr_en_d   = 1'b1;
                wr_addr_d = {row_q, col_q};
                wr_data_d = {pix_q, spi_byte_data_i};
                col_d     = col_q + COL_BITS'(1);
                if (&col_q) begin
                  row_d = row_q + ROW_BITS'(1);
                end
                if ((&col_q) && (&row_q)) begin
                  wr_done_d = 1'b1;
                  state_d   = ST_WAIT_SWAP;
                end
              end
            endcase
          end
          ST_WAIT_SWAP: ovf_d = 1'b1;
          default: ;
        endcase
      end
    end

    // A scan-end pulse coincident with the final write (wr_done_q high) is
    // too early: the display may already be re-reading the old buffer.
    if ((state_q == ST_WAIT_SWAP) && rd_frame_end_i && !wr_done_q) begin
      frame_sel_d = ~frame_sel_q;
      wr_sel_d    = frame_sel_q;
      state_d     = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      phase_q     <= 2'd0;
      pix_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_sel_q    <= 1'b1;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_done_q   <= 1'b0;
      frame_sel_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      phase_q     <= phase_d;
      pix_q       <= pix_d;
      wr_en_q     <= wr_en_d;
      wr_sel_q    <= wr_sel_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_done_q   <= wr_done_d;
      frame_sel_q <= frame_sel_d;
      ovf_q       <= ovf_d;
    end
  end

  assign ram_wr_en_o   = wr_en_q;
  assign ram_wr_sel_o  = wr_sel_q;
  assign ram_wr_addr_o = wr_addr_q;
  assign ram_wr_data_o = wr_data_q;
  assign ram_wr_done_o = wr_done_q;
  assign frame_sel_o   = frame_sel_q;
  assign ovf_o         = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_hub75e_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hub75e_frame_writer
// Purpose  : Directed self-checking bench for hub75e_frame_writer. Expected
//            writes are queued as stimulus is driven and compared by a
//            monitor whenever the write strobe appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hub75e_frame_writer;

  localparam int NPIX = 4096;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        dc    = 1'b0;
  logic        vld   = 1'b0;
  logic [7:0]  bdata = 8'h00;
  logic        rd_end = 1'b0;

  logic        wr_en;
  logic        wr_sel;
  logic [11:0] wr_addr;
  logic [23:0] wr_data;
  logic        wr_done;
  logic        frame_sel;
  logic        ovf;

  hub75e_frame_writer #(
    .COL_BITS     (6),
    .ROW_BITS     (6),
    .CMD_WR_START (8'h2C)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .dc_i            (dc),
    .spi_byte_vld_i  (vld),
    .spi_byte_data_i (bdata),
    .rd_frame_end_i  (rd_end),
    .ram_wr_en_o     (wr_en),
    .ram_wr_sel_o    (wr_sel),
    .ram_wr_addr_o   (wr_addr),
    .ram_wr_data_o   (wr_data),
    .ram_wr_done_o   (wr_done),
    .frame_sel_o     (frame_sel),
    .ovf_o           (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] addr;
    logic [23:0] data;
    logic        done;
    logic        sel;
  } wr_t;

  wr_t  exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   wr_cnt   = 0;
  int   done_cnt = 0;
  logic exp_sel  = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en === 1'b1) begin
        wr_cnt++;
        if (wr_done === 1'b1) done_cnt++;
        chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.addr));
          chk("wr_data", 32'(wr_data), 32'(e.data));
          chk("wr_done", 32'(wr_done), 32'(e.done));
          chk("wr_sel",  32'(wr_sel),  32'(e.sel));
        end
      end else begin
        chk("done_without_write", 32'(wr_done), 32'd0);
      end
    end
  end

  task automatic send(input logic d, input logic [7:0] b);
    dc    = d;
    bdata = b;
    vld   = 1'b1;
    @(negedge clk);
    vld   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_wr(input logic [11:0] a, input logic [23:0] d, input logic dn);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.done = dn;
    e.sel  = exp_sel;
    exp_q.push_back(e);
  endtask

  function automatic logic [7:0] pb(input int f, input int i);
    return 8'(i * 13 + f * 5 + 7);
  endfunction

  // Opens a frame and sends npix pixels back to back; optionally pulses the
  // scan-end input in the very cycle the final write is presented.
  task automatic send_frame(input int f, input int npix, input bit sim_end);
    logic [7:0] r, g, b;
    send(1'b0, 8'h2C);
    for (int p = 0; p < npix; p++) begin
      r = pb(f, 3 * p);
      g = pb(f, 3 * p + 1);
      b = pb(f, 3 * p + 2);
      send(1'b1, r);
      send(1'b1, g);
      expect_wr(12'(p), {r, g, b}, p == NPIX - 1);
      send(1'b1, b);
    end
    if (sim_end) begin
      rd_end = 1'b1;
      @(negedge clk);
      rd_end = 1'b0;
    end
  endtask

  task automatic pulse_rd_end();
    rd_end = 1'b1;
    @(negedge clk);
    rd_end = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_en"},     32'(wr_en),     32'd0);
    chk({tag, "_wr_addr"},   32'(wr_addr),   32'd0);
    chk({tag, "_wr_data"},   32'(wr_data),   32'd0);
    chk({tag, "_wr_done"},   32'(wr_done),   32'd0);
    chk({tag, "_frame_sel"}, 32'(frame_sel), 32'd0);
    chk({tag, "_wr_sel"},    32'(wr_sel),    32'd1);
    chk({tag, "_ovf"},       32'(ovf),       32'd0);
  endtask

  initial begin
    // Reset state, during and just after reset.
    idle(3);
    chk_reset_outputs("rst_hold");
    rst_n = 1'b1;
    idle(2);
    chk_reset_outputs("rst_rel");

    // Data in IDLE before any start command: dropped silently.
    send(1'b1, 8'h55);
    send(1'b1, 8'h66);
    send(1'b1, 8'h77);
    idle(3);
    chk("idle_data_ovf",    32'(ovf), 32'd0);
    chk("idle_data_no_wr",  32'(wr_cnt), 32'd0);

    // Basic pixel with one-cycle latency and a one-cycle strobe.
    send(1'b0, 8'h2C);
    send(1'b1, 8'h11);
    send(1'b1, 8'h22);
    expect_wr(12'h000, 24'h112233, 1'b0);
    send(1'b1, 8'h33);
    chk("basic_en",   32'(wr_en),   32'd1);
    chk("basic_addr", 32'(wr_addr), 32'h000);
    chk("basic_data", 32'(wr_data), 32'h112233);
    chk("basic_sel",  32'(wr_sel),  32'd1);
    idle(1);
    chk("basic_en_drop",   32'(wr_en),   32'd0);
    chk("basic_addr_hold", 32'(wr_addr), 32'h000);
    chk("basic_data_hold", 32'(wr_data), 32'h112233);

    // A non-start command in the middle of a pixel is ignored.
    send(1'b0, 8'h2C);
    send(1'b1, 8'h01);
    send(1'b0, 8'h2A);
    send(1'b1, 8'h02);
    expect_wr(12'h000, 24'h010203, 1'b0);
    send(1'b1, 8'h03);
    idle(2);

    // Resync: a start command discards the partial pixel.
    send(1'b0, 8'h2C);
    send(1'b1, 8'h01);
    send(1'b1, 8'h02);
    send(1'b0, 8'h2C);
    send(1'b1, 8'h10);
    send(1'b1, 8'h20);
    expect_wr(12'h000, 24'h102030, 1'b0);
    send(1'b1, 8'h30);
    idle(2);
    chk("resync_wr_cnt", 32'(wr_cnt), 32'd3);

    // Full frame, then swap on the next scan end.
    send_frame(0, NPIX, 1'b0);
    idle(5);
    chk("f0_done_cnt",   32'(done_cnt), 32'd1);
    chk("f0_wr_cnt",     32'(wr_cnt), 32'(3 + NPIX));
    chk("f0_queue",      32'(exp_q.size()), 32'd0);
    chk("f0_sel_hold",   32'(frame_sel), 32'd0);
    chk("f0_wrsel_hold", 32'(wr_sel), 32'd1);
    chk("f0_ovf",        32'(ovf), 32'd0);
    pulse_rd_end();
    chk("f0_swap_sel",   32'(frame_sel), 32'd1);
    chk("f0_swap_wrsel", 32'(wr_sel), 32'd0);
    exp_sel = 1'b0;

    // Scan end coincident with the final write must not swap.
    send_frame(1, NPIX, 1'b1);
    chk("f1_no_swap",    32'(frame_sel), 32'd1);
    chk("f1_done_cnt",   32'(done_cnt), 32'd2);

    // Overflow while waiting for the swap.
    send(1'b1, 8'hAA);
    send(1'b0, 8'h2C);
    idle(2);
    chk("ovf_set",       32'(ovf), 32'd1);
    chk("ovf_no_wr",     32'(wr_cnt), 32'(3 + 2 * NPIX));
    chk("ovf_no_swap",   32'(frame_sel), 32'd1);
    idle(6);
    pulse_rd_end();
    chk("f1_swap_sel",   32'(frame_sel), 32'd0);
    chk("f1_swap_wrsel", 32'(wr_sel), 32'd1);
    chk("ovf_after_swap", 32'(ovf), 32'd1);
    exp_sel = 1'b1;

    // Another frame: overflow stays sticky.
    send_frame(2, NPIX, 1'b0);
    idle(3);
    pulse_rd_end();
    chk("f2_swap_sel",   32'(frame_sel), 32'd1);
    chk("f2_done_cnt",   32'(done_cnt), 32'd3);
    chk("ovf_sticky",    32'(ovf), 32'd1);
    exp_sel = 1'b0;

    // Reset after 100 pixels of a new frame: asynchronous return to reset.
    send_frame(3, 100, 1'b0);
    chk("pre_rst_ovf",   32'(ovf), 32'd1);
    chk("pre_rst_sel",   32'(frame_sel), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    chk("rst_queue",     32'(exp_q.size()), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(5);
    chk("rst_no_done",   32'(done_cnt), 32'd3);
    chk("rst_sel",       32'(frame_sel), 32'd0);
    chk("rst_wr_cnt",    32'(wr_cnt), 32'(3 + 3 * NPIX + 100));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
